// File: rtl/floor_request_scheduler.sv
// Three-floor cabin scheduler: latches calls, serves them in SCAN order, times travel/door dwell.
// Optional homing to floor1 after a long idle spell is enabled by defining SCHED_PARK_EN.
//
// state       | meaning
// S_IDLE      | parked at a floor, door closed, waiting for a lamp
// S_MOVING    | travelling one segment at a time in dir_up
// S_DOOR_OPEN | door dwell, held open while overloaded
// S_SOS_STOP  | emergency raised mid-shaft, finishing the current segment
// S_SOS_HOLD  | emergency hold, door open, calls ignored
// S_PARK      | homing towards floor1 (SCHED_PARK_EN only)
module floor_request_scheduler #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int TRAVEL_SEC = 2,
    parameter int DOOR_SEC   = 3,
    parameter int PARK_SEC   = 10
) (
    input  logic       clk_50,
    input  logic       reset,
    input  logic [2:0] call_req,
    input  logic       sos_mode,
    input  logic       weight_limit_exceeded,
    output logic       led1,
    output logic       led2,
    output logic       led3,
    output logic       floor1,
    output logic       floor2,
    output logic       floor3,
    output logic       door,
    output logic       moving,
    output logic       dir_up
);

    localparam int TRAVEL_CYC = CLK_FREQ * TRAVEL_SEC;
    localparam int DOOR_CYC   = CLK_FREQ * DOOR_SEC;
    localparam int PARK_CYC   = CLK_FREQ * PARK_SEC;
    localparam int MAX_TD     = (TRAVEL_CYC > DOOR_CYC) ? TRAVEL_CYC : DOOR_CYC;
    localparam int MAX_CYC    = (MAX_TD > PARK_CYC) ? MAX_TD : PARK_CYC;
    localparam int TW         = $clog2(MAX_CYC) + 1;

    localparam logic [TW-1:0] TRAVEL_LD = TW'(TRAVEL_CYC - 1);
    localparam logic [TW-1:0] DOOR_LD   = TW'(DOOR_CYC - 1);
`ifdef SCHED_PARK_EN
    localparam logic [TW-1:0] PARK_LD   = TW'(PARK_CYC - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_MOVING,
        S_DOOR_OPEN,
        S_SOS_STOP,
        S_SOS_HOLD
`ifdef SCHED_PARK_EN
        , S_PARK
`endif
    } state_t;

    state_t          state;
    logic [2:0]      led;
    logic [2:0]      flr;
    logic [TW-1:0]   timer;
`ifdef SCHED_PARK_EN
    logic [TW-1:0]   idle_cnt;
`endif

    logic            stationary;
    logic [2:0]      led_set;
    logic [2:0]      led_nx;
    logic            here_call;
    logic            ahead;
    logic [2:0]      nxt_flr;

    function automatic logic [2:0] above_mask(input logic [2:0] f);
        return f[0] ? 3'b110 : (f[1] ? 3'b100 : 3'b000);
    endfunction

    function automatic logic [2:0] below_mask(input logic [2:0] f);
        return f[2] ? 3'b011 : (f[1] ? 3'b001 : 3'b000);
    endfunction

    assign {led3, led2, led1}       = led;
    assign {floor3, floor2, floor1} = flr;

    // A call at the floor the cabin is standing at opens the door instead of lighting a lamp.
    always_comb begin
        stationary = (state == S_IDLE) || (state == S_DOOR_OPEN) || (state == S_SOS_HOLD);
        led_set    = sos_mode ? 3'b000 : (call_req & ~(stationary ? flr : 3'b000));
        led_nx     = led | led_set;
        here_call  = !sos_mode && stationary && |(call_req & flr);
        ahead      = dir_up ? |(led & above_mask(flr)) : |(led & below_mask(flr));
        nxt_flr    = dir_up ? (flr[2] ? flr : {flr[1:0], 1'b0})
                            : (flr[0] ? flr : {1'b0, flr[2:1]});
    end

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            led      <= 3'b000;
            flr      <= 3'b001;
            door     <= 1'b0;
            moving   <= 1'b0;
            dir_up   <= 1'b1;
            timer    <= '0;
`ifdef SCHED_PARK_EN
            idle_cnt <= '0;
`endif
        end else begin
            led <= led_nx;
            case (state)
                S_IDLE: begin
                    if (sos_mode) begin
                        state <= S_SOS_HOLD;
                        door  <= 1'b1;
                        led   <= 3'b000;
                    end else if (here_call || |(led & flr)) begin
                        state <= S_DOOR_OPEN;
                        door  <= 1'b1;
                        timer <= DOOR_LD;
                        led   <= led_nx & ~flr;
                    end else if (|led) begin
                        state  <= S_MOVING;
                        moving <= 1'b1;
                        dir_up <= ahead ? dir_up : ~dir_up;
                        timer  <= TRAVEL_LD;
`ifdef SCHED_PARK_EN
                    end else if (!(|led_set) && !flr[0]) begin
                        if (idle_cnt == '0) begin
                            state  <= S_PARK;
                            moving <= 1'b1;
                            dir_up <= 1'b0;
                            timer  <= TRAVEL_LD;
                        end else begin
                            idle_cnt <= idle_cnt - TW'(1);
                        end
                    end else begin
                        idle_cnt <= PARK_LD;
`endif
                    end
                end
                S_MOVING, S_SOS_STOP
`ifdef SCHED_PARK_EN
                , S_PARK
`endif
                : begin
                    if (timer != '0) begin
                        timer <= timer - TW'(1);
                        if (sos_mode) state <= S_SOS_STOP;
                    end else begin
                        flr <= nxt_flr;
                        if (state == S_SOS_STOP || sos_mode) begin
                            state  <= S_SOS_HOLD;
                            moving <= 1'b0;
                            door   <= 1'b1;
                            led    <= 3'b000;
                        end else if (|(led_nx & nxt_flr)) begin
                            state  <= S_DOOR_OPEN;
                            moving <= 1'b0;
                            door   <= 1'b1;
                            timer  <= DOOR_LD;
                            led    <= led_nx & ~nxt_flr;
                        end else if (state == S_MOVING) begin
                            timer <= TRAVEL_LD;
                            if (nxt_flr[2]) dir_up <= 1'b0;
                            if (nxt_flr[0]) dir_up <= 1'b1;
`ifdef SCHED_PARK_EN
                        end else if (|led_nx) begin
                            // homing aborted: resume SCAN from this floor
                            state  <= S_MOVING;
                            timer  <= TRAVEL_LD;
                            dir_up <= !(|(led_nx & below_mask(nxt_flr)));
                        end else if (nxt_flr[0]) begin
                            state    <= S_IDLE;
                            moving   <= 1'b0;
                            dir_up   <= 1'b1;
                            idle_cnt <= PARK_LD;
                        end else begin
                            timer <= TRAVEL_LD;
`endif
                        end
                    end
                end
                S_DOOR_OPEN: begin
                    if (sos_mode) begin
                        state <= S_SOS_HOLD;
                        led   <= 3'b000;
                    end else if (here_call) begin
                        timer <= DOOR_LD;
                    end else if (timer != '0) begin
                        timer <= timer - TW'(1);
                    end else if (weight_limit_exceeded) begin
                        timer <= DOOR_LD;
                    end else begin
                        state <= S_IDLE;
                        door  <= 1'b0;
`ifdef SCHED_PARK_EN
                        idle_cnt <= PARK_LD;
`endif
                    end
                end
                S_SOS_HOLD: begin
                    if (!sos_mode) begin
                        state <= S_DOOR_OPEN;
                        timer <= DOOR_LD;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_floor_request_scheduler.sv
// Directed bench for floor_request_scheduler with short timings (travel 4, door 6, park 10 cycles).
module tb_floor_request_scheduler;

    logic       clk_50 = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] call_req = 3'b000;
    logic       sos_mode = 1'b0;
    logic       weight_limit_exceeded = 1'b0;
    logic       led1, led2, led3, floor1, floor2, floor3, door, moving, dir_up;
    logic [8:0] obs;
    int         total = 0;
    int         bad = 0;

    floor_request_scheduler #(
        .CLK_FREQ(2), .TRAVEL_SEC(2), .DOOR_SEC(3), .PARK_SEC(5)
    ) dut (
        .clk_50(clk_50), .reset(reset), .call_req(call_req), .sos_mode(sos_mode),
        .weight_limit_exceeded(weight_limit_exceeded),
        .led1(led1), .led2(led2), .led3(led3),
        .floor1(floor1), .floor2(floor2), .floor3(floor3),
        .door(door), .moving(moving), .dir_up(dir_up)
    );

    always #5 clk_50 = ~clk_50;

    // {led3,led2,led1, floor3,floor2,floor1, door, moving, dir_up}
    assign obs = {led3, led2, led1, floor3, floor2, floor1, door, moving, dir_up};

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_50);
            #1;
        end
    endtask

    task automatic pulse(input logic [2:0] c);
        call_req = c;
        step(1);
        call_req = 3'b000;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        step(2);
        total++;
        if (obs !== 9'b000_001_0_0_1) begin bad++; $display("FAIL reset_state: got %b want %b", obs, 9'b000_001_0_0_1); end
        reset = 1'b0;
        step(1);
    endtask

    task automatic test_up_trip;
        pulse(3'b100);
        total++;
        if (obs !== 9'b100_001_0_0_1) begin bad++; $display("FAIL trip_lamp: got %b want %b", obs, 9'b100_001_0_0_1); end
        step(1);
        total++;
        if (obs !== 9'b100_001_0_1_1) begin bad++; $display("FAIL trip_start: got %b want %b", obs, 9'b100_001_0_1_1); end
        step(3);
        total++;
        if (obs !== 9'b100_001_0_1_1) begin bad++; $display("FAIL trip_seg1_early: got %b want %b", obs, 9'b100_001_0_1_1); end
        step(1);
        total++;
        if (obs !== 9'b100_010_0_1_1) begin bad++; $display("FAIL trip_floor2: got %b want %b", obs, 9'b100_010_0_1_1); end
        step(4);
        total++;
        if (obs !== 9'b000_100_1_0_1) begin bad++; $display("FAIL trip_arrive3: got %b want %b", obs, 9'b000_100_1_0_1); end
        step(5);
        total++;
        if (obs !== 9'b000_100_1_0_1) begin bad++; $display("FAIL trip_dwell: got %b want %b", obs, 9'b000_100_1_0_1); end
        step(1);
        total++;
        if (obs !== 9'b000_100_0_0_1) begin bad++; $display("FAIL trip_close: got %b want %b", obs, 9'b000_100_0_0_1); end
    endtask

    task automatic test_current_floor;
        pulse(3'b100);
        total++;
        if (obs !== 9'b000_100_1_0_1) begin bad++; $display("FAIL here_call_door: got %b want %b", obs, 9'b000_100_1_0_1); end
        step(6);
        total++;
        if (obs !== 9'b000_100_0_0_1) begin bad++; $display("FAIL here_call_close: got %b want %b", obs, 9'b000_100_0_0_1); end
    endtask

    task automatic test_reset_mid_move;
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        pulse(3'b100);
        step(1 + 4 + 2);
        total++;
        if (obs !== 9'b100_010_0_1_1) begin bad++; $display("FAIL mid_move_pre: got %b want %b", obs, 9'b100_010_0_1_1); end
        reset = 1'b1;
        #1;
        total++;
        if (obs !== 9'b000_001_0_0_1) begin bad++; $display("FAIL mid_move_reset: got %b want %b", obs, 9'b000_001_0_0_1); end
        step(1);
        reset = 1'b0;
    endtask

    task automatic test_scan_order;
        pulse(3'b010);
        step(1 + 4);
        total++;
        if (obs !== 9'b000_010_1_0_1) begin bad++; $display("FAIL scan_at2: got %b want %b", obs, 9'b000_010_1_0_1); end
        step(6);
        pulse(3'b101);
        total++;
        if (obs !== 9'b101_010_0_0_1) begin bad++; $display("FAIL scan_lamps: got %b want %b", obs, 9'b101_010_0_0_1); end
        step(1);
        total++;
        if (obs !== 9'b101_010_0_1_1) begin bad++; $display("FAIL scan_go_up: got %b want %b", obs, 9'b101_010_0_1_1); end
        step(4);
        total++;
        if (obs !== 9'b001_100_1_0_1) begin bad++; $display("FAIL scan_at3: got %b want %b", obs, 9'b001_100_1_0_1); end
        step(6);
        total++;
        if (obs !== 9'b001_100_0_0_1) begin bad++; $display("FAIL scan_close3: got %b want %b", obs, 9'b001_100_0_0_1); end
        step(1);
        total++;
        if (obs !== 9'b001_100_0_1_0) begin bad++; $display("FAIL scan_flip: got %b want %b", obs, 9'b001_100_0_1_0); end
        step(4);
        total++;
        if (obs !== 9'b001_010_0_1_0) begin bad++; $display("FAIL scan_pass2: got %b want %b", obs, 9'b001_010_0_1_0); end
        step(4);
        total++;
        if (obs !== 9'b000_001_1_0_0) begin bad++; $display("FAIL scan_at1: got %b want %b", obs, 9'b000_001_1_0_0); end
        step(6);
    endtask

    task automatic test_overload;
        pulse(3'b001);
        weight_limit_exceeded = 1'b1;
        step(6);
        total++;
        if (obs !== 9'b000_001_1_0_0) begin bad++; $display("FAIL overload_hold: got %b want %b", obs, 9'b000_001_1_0_0); end
        weight_limit_exceeded = 1'b0;
        step(5);
        total++;
        if (door !== 1'b1) begin bad++; $display("FAIL overload_redwell: got %b want %b", door, 1'b1); end
        step(1);
        total++;
        if (door !== 1'b0) begin bad++; $display("FAIL overload_close: got %b want %b", door, 1'b0); end
    endtask

    task automatic test_sos;
        pulse(3'b100);
        step(1);
        total++;
        if (obs !== 9'b100_001_0_1_1) begin bad++; $display("FAIL sos_trip_start: got %b want %b", obs, 9'b100_001_0_1_1); end
        step(2);
        sos_mode = 1'b1;
        call_req = 3'b010;
        step(1);
        call_req = 3'b000;
        total++;
        if (obs !== 9'b100_001_0_1_1) begin bad++; $display("FAIL sos_finish_seg: got %b want %b", obs, 9'b100_001_0_1_1); end
        step(1);
        total++;
        if (obs !== 9'b000_010_1_0_1) begin bad++; $display("FAIL sos_stop2: got %b want %b", obs, 9'b000_010_1_0_1); end
        pulse(3'b001);
        step(3);
        total++;
        if (obs !== 9'b000_010_1_0_1) begin bad++; $display("FAIL sos_ignore_call: got %b want %b", obs, 9'b000_010_1_0_1); end
        sos_mode = 1'b0;
        step(6);
        total++;
        if (obs !== 9'b000_010_1_0_1) begin bad++; $display("FAIL sos_release_dwell: got %b want %b", obs, 9'b000_010_1_0_1); end
        step(1);
        total++;
        if (obs !== 9'b000_010_0_0_1) begin bad++; $display("FAIL sos_release_idle: got %b want %b", obs, 9'b000_010_0_0_1); end
    endtask

`ifdef SCHED_PARK_EN
    task automatic test_park;
        step(9);
        total++;
        if (obs !== 9'b000_010_0_0_1) begin bad++; $display("FAIL park_wait: got %b want %b", obs, 9'b000_010_0_0_1); end
        step(1);
        total++;
        if (obs !== 9'b000_010_0_1_0) begin bad++; $display("FAIL park_start: got %b want %b", obs, 9'b000_010_0_1_0); end
        step(4);
        total++;
        if (obs !== 9'b000_001_0_0_1) begin bad++; $display("FAIL park_home: got %b want %b", obs, 9'b000_001_0_0_1); end
    endtask
`endif

    initial begin
        test_reset;
        test_up_trip;
        test_current_floor;
        test_reset_mid_move;
        test_scan_order;
        test_overload;
        test_sos;
`ifdef SCHED_PARK_EN
        test_park;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
